// File: rtl/riscv_pkg.sv
// Shared definitions for the program loaders: loader state encoding and frame geometry.
package riscv_pkg;

  typedef enum logic [2:0] {
    LD_HDR0 = 3'd0,
    LD_HDR1 = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_RUN  = 3'd4,
    LD_ERR  = 3'd5
  } loader_state_e;

  localparam int unsigned LD_HDR_BYTES      = 2;
  localparam int unsigned LD_BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_word_asm.sv
// Assembles little-endian bytes into 32-bit words; word_valid pulses the cycle after the 4th byte.
module loader_word_asm
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [1:0]  byte_idx
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] sr_q, sr_d;
  logic        valid_q, valid_d;

  always_comb begin
    idx_d   = idx_q;
    sr_d    = sr_q;
    valid_d = 1'b0;
    if (clear) begin
      idx_d = 2'd0;
    end else if (byte_valid) begin
      // Shift in at the top so the first byte ends up in bits [7:0].
      sr_d  = {byte_data, sr_q[31:8]};
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'(LD_BYTES_PER_WORD - 1)) valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 2'd0;
      sr_q    <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid = valid_q;
  assign word_data  = sr_q;
  assign byte_idx   = idx_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the core in reset until a
// length-prefixed, checksummed image has been written.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded,
  output logic [2:0]  dbg_state
);

  // Handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
  // in_ready depends only on the state, never on in_valid.

  loader_state_e state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [7:0]    csum_q, csum_d;
  logic [15:0]   words_q, words_d;
  logic          accept;
  logic          reload_take;
  logic          word_valid;
  logic [31:0]   word_data;
  logic [1:0]    byte_idx;
  logic [15:0]   hdr_count;

  assign in_ready  = (state_q == LD_HDR0) || (state_q == LD_HDR1) ||
                     (state_q == LD_DATA) || (state_q == LD_CSUM);
  assign accept    = in_valid && in_ready;
  assign hdr_count = {in_data, count_q[7:0]};

  loader_word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload_take),
    .byte_valid (accept && (state_q == LD_DATA)),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word_data  (word_data),
    .byte_idx   (byte_idx)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    csum_d      = csum_q;
    words_d     = words_q;
    reload_take = 1'b0;
    if (word_valid) words_d = words_q + 16'd1;
    case (state_q)
      LD_HDR0: if (accept) begin
        count_d[7:0] = in_data;
        csum_d       = csum_q + in_data;
        state_d      = LD_HDR1;
      end
      LD_HDR1: if (accept) begin
        count_d[15:8] = in_data;
        csum_d        = csum_q + in_data;
        if (hdr_count == 16'd0)                 state_d = LD_CSUM;
        else if (32'(hdr_count) > IMEM_WORDS)   state_d = LD_ERR;
        else                                    state_d = LD_DATA;
      end
      LD_DATA: if (accept) begin
        csum_d = csum_q + in_data;
        // The previous word's write has always retired by the time the next word's last
        // byte arrives, so words_q counts every earlier word here.
        if (byte_idx == 2'(LD_BYTES_PER_WORD - 1) && words_q == count_q - 16'd1)
          state_d = LD_CSUM;
      end
      LD_CSUM: if (accept) begin
        state_d = (in_data == csum_q) ? LD_RUN : LD_ERR;
      end
      LD_RUN, LD_ERR: if (reload) begin
        reload_take = 1'b1;
        state_d     = LD_HDR0;
        count_d     = 16'd0;
        csum_d      = 8'd0;
        words_d     = 16'd0;
      end
      default: state_d = LD_HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_HDR0;
      count_q <= 16'd0;
      csum_q  <= 8'd0;
      words_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      words_q <= words_d;
    end
  end

  assign imem_we      = word_valid;
  assign imem_wdata   = word_data;
  assign imem_addr    = BASE_ADDR + {14'd0, words_q, 2'b00};
  assign core_rst     = (state_q != LD_RUN);
  assign done         = (state_q == LD_RUN);
  assign error        = (state_q == LD_ERR);
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame load, checksum error, oversize, zero length,
// stalls, reset mid-word, reload and full-depth image.
module tb_imem_loader;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, reload;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, core_rst, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int w0;
  logic [63:0] exp_q[$];
  logic [7:0]  nom[11] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                           8'h13, 8'h01, 8'h50, 8'h00, 8'h49};

  imem_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .done(done), .error(error), .words_loaded(words_loaded),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the write port
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_cnt++;
      check("wr_core_rst", 64'(core_rst), 64'd1);
      check("wr_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("wr_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
    end
  end

  // Drivers
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; reload = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    in_valid = 1'b0;
    reload   = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic push_nominal();
    exp_q.push_back({32'h0000_0000, 32'h0050_0093});
    exp_q.push_back({32'h0000_0004, 32'h0050_0113});
  endtask

  initial begin
    logic [7:0] sum;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(LD_HDR0));
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_done_err", {62'd0, done, error}, 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    rst = 1'b0;

    // Nominal two-word image, back-to-back bytes
    w0 = wr_cnt;
    push_nominal();
    for (int i = 0; i < 11; i++) send_byte(nom[i]);
    idle(1);
    check("nom_state", 64'(dbg_state), 64'(LD_RUN));
    check("nom_done", 64'(done), 64'd1);
    check("nom_core_rst", 64'(core_rst), 64'd0);
    check("nom_error", 64'(error), 64'd0);
    check("nom_in_ready", 64'(in_ready), 64'd0);
    check("nom_words", 64'(words_loaded), 64'd2);
    check("nom_wr_cnt", 64'(wr_cnt - w0), 64'd2);

    // Reload from RUN, then one-word image (checksum 01+00+EF+BE+AD+DE = 0x339 -> 0x39)
    @(negedge clk);
    reload = 1'b1;
    check("rl_before_core_rst", 64'(core_rst), 64'd0);
    @(negedge clk);
    reload = 1'b0;
    check("rl_state", 64'(dbg_state), 64'(LD_HDR0));
    check("rl_core_rst", 64'(core_rst), 64'd1);
    check("rl_done", 64'(done), 64'd0);
    check("rl_words", 64'(words_loaded), 64'd0);
    w0 = wr_cnt;
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    send_byte(8'h39);
    idle(1);
    check("rl_run", 64'(dbg_state), 64'(LD_RUN));
    check("rl_words_after", 64'(words_loaded), 64'd1);
    check("rl_wr_cnt", 64'(wr_cnt - w0), 64'd1);

    // Reload is ignored outside RUN/ERR
    pulse_reload();
    send_byte(8'h01);
    pulse_reload();
    check("rl_ignored_hdr1", 64'(dbg_state), 64'(LD_HDR1));

    // Bad checksum
    do_reset();
    w0 = wr_cnt;
    push_nominal();
    for (int i = 0; i < 10; i++) send_byte(nom[i]);
    send_byte(8'h48);
    idle(1);
    check("bad_state", 64'(dbg_state), 64'(LD_ERR));
    check("bad_error", 64'(error), 64'd1);
    check("bad_core_rst", 64'(core_rst), 64'd1);
    check("bad_in_ready", 64'(in_ready), 64'd0);
    check("bad_done", 64'(done), 64'd0);
    check("bad_wr_cnt", 64'(wr_cnt - w0), 64'd2);

    // Reload from ERR, oversize header (count = 257)
    pulse_reload();
    check("ov_reload_state", 64'(dbg_state), 64'(LD_HDR0));
    check("ov_reload_error", 64'(error), 64'd0);
    w0 = wr_cnt;
    send_byte(8'h01); send_byte(8'h01);
    idle(1);
    check("ov_state", 64'(dbg_state), 64'(LD_ERR));
    check("ov_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    idle(1);
    check("ov_still_err", 64'(dbg_state), 64'(LD_ERR));
    check("ov_wr_cnt", 64'(wr_cnt - w0), 64'd0);

    // Zero-length image
    pulse_reload();
    w0 = wr_cnt;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(1);
    check("zero_state", 64'(dbg_state), 64'(LD_RUN));
    check("zero_core_rst", 64'(core_rst), 64'd0);
    check("zero_wr_cnt", 64'(wr_cnt - w0), 64'd0);

    // Nominal image with random in_valid gaps
    do_reset();
    w0 = wr_cnt;
    push_nominal();
    for (int i = 0; i < 11; i++) begin
      idle($urandom_range(0, 3));
      send_byte(nom[i]);
      if (i == 3) begin
        idle(5);
        check("stall_state", 64'(dbg_state), 64'(LD_DATA));
        check("stall_words", 64'(words_loaded), 64'd0);
      end
    end
    idle(1);
    check("stall_run", 64'(dbg_state), 64'(LD_RUN));
    check("stall_words_end", 64'(words_loaded), 64'd2);
    check("stall_wr_cnt", 64'(wr_cnt - w0), 64'd2);

    // Reset after the third data byte
    do_reset();
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) send_byte(nom[i]);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_state", 64'(dbg_state), 64'(LD_HDR0));
    check("mid_rst_words", 64'(words_loaded), 64'd0);
    check("mid_rst_core_rst", 64'(core_rst), 64'd1);
    idle(4);
    check("mid_rst_wr_cnt", 64'(wr_cnt - w0), 64'd0);

    // Full-depth image: count == IMEM_WORDS, word w = {4{w}}
    do_reset();
    w0  = wr_cnt;
    sum = 8'h01;
    send_byte(8'h00); send_byte(8'h01);
    for (int w = 0; w < 256; w++) begin
      logic [7:0] b;
      b = 8'(w);
      exp_q.push_back({32'(4 * w), {4{b}}});
      for (int k = 0; k < 4; k++) begin
        send_byte(b);
        sum = sum + b;
      end
    end
    send_byte(sum);
    idle(1);
    check("full_state", 64'(dbg_state), 64'(LD_RUN));
    check("full_words", 64'(words_loaded), 64'd256);
    check("full_wr_cnt", 64'(wr_cnt - w0), 64'd256);

    idle(2);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
